mux_share_arbiter: RTL and testbench
====================================

// Module: mux_share_arbiter
// PURPOSE
//  Round-robin arbiter sharing one registered N:1 W-bit mux datapath among N requesters.
//  Each requester holds req high for the whole transaction; the arbiter grants one owner,
//  steers that owner's data to out_data, and moves on when the owner drops req.
//  One dead cycle between owners (break-before-make); sits in front of shared mux/gate logic.
// PARAMETERS
//  N        4   number of requesters (2..16)
//  W        8   data width per requester
//  HOLD_MAX 16  max grant length in cycles; used only with ARB_TIMEOUT_EN (>=2)
// PORTS
//  clk       in   1    rising-edge clock
//  rst_n     in   1    asynchronous active-low reset
//  req       in   N    request per requester; held high until done
//  data_in   in   N*W  requester i data on data_in[i*W +: W]
//  grant     out  N    one-hot grant, registered; all-zero when no owner
//  out_valid out  1    out_data carries owner data this cycle
//  out_data  out  W    registered mux output; 0 when out_valid=0
//  busy      out  1    1 in GRANT or RELEASE state
//  timeout   out  1    1-cycle pulse on forced revoke; constant 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, grant=0, out_valid=0, out_data=0, busy=0, timeout=0,
//   ptr=0, owner=0, hold_cnt=0. Reset mid-grant drops everything immediately.
//  States: IDLE, GRANT, RELEASE. All outputs registered.
//  Pick rule: first set req bit scanning ptr, ptr+1, .. mod N. ptr=0 after reset.
//  IDLE: if |req at edge -> GRANT, owner=pick, grant=1<<owner, out_valid=1,
//   out_data=data_in[owner]. Latency: req seen at edge k -> grant/out_valid high after edge k.
//  GRANT: each edge while req[owner]=1: out_data <= data_in[owner] (1-cycle latency).
//   req[owner]=0 at edge -> RELEASE: grant=0, out_valid=0, out_data=0, ptr=(owner+1) mod N.
//   Other req bits ignored while GRANT (no preemption).
//  RELEASE (exactly 1 cycle): if |req -> GRANT with new pick from updated ptr; else IDLE.
//  Owner drops req and raises it again: still goes through RELEASE; re-granted only if it is
//   the first set bit from the new ptr.
//  Simultaneous reqs in IDLE: lowest index >= ptr wins, wrapping past N-1 to 0.
//  req=0 in IDLE: outputs stay at reset values. busy=1 iff state != IDLE.
//  grant is always one-hot or zero; never two owners in one cycle.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: hold_cnt clears on entering GRANT, increments each GRANT cycle;
//   when hold_cnt==HOLD_MAX-1 and req[owner] still 1 -> RELEASE with timeout=1 for that
//   one cycle; ptr advances as for a normal release. Owner must drop req to be fair; if still
//   high it competes normally from the new ptr.
//  Not defined: no hold counter, grant lasts until req[owner]=0, timeout tied 0.
// TESTING
//  1 Reset: rst_n=0 mid-grant (owner 2) -> grant=0, out_valid=0, out_data=0 same cycle.
//  2 Single: req=4'b0010, data_in[1]=8'hA5 -> one edge later grant=4'b0010, out_data=8'hA5;
//    drop req -> RELEASE cycle grant=0, then IDLE, busy=0.
//  3 Round robin: req=4'b1111 held, each owner drops req 3 cycles after its grant then re-raises
//    -> grant order 0001,0010,0100,1000,0001 with one zero-grant cycle between each.
//  4 Wrap: ptr=3 (after owner 2), req=4'b0001 -> owner 0 granted; req=4'b1001 -> owner 3 first.
//  5 Data tracking: owner 1 granted, data_in[1] 8'h10->8'h11 -> out_data 8'h11 one edge later;
//    data_in[0] changes have no effect.
//  6 Timeout (ARB_TIMEOUT_EN, HOLD_MAX=16): owner 0 holds req 40 cycles, req[1]=1 ->
//    grant revoked after 16 GRANT cycles, timeout pulse 1 cycle, owner 1 granted next;
//    without macro owner 0 keeps grant all 40 cycles, timeout stays 0.

Source files
------------

// File: rtl/mux_share_arbiter.sv
// Round-robin owner arbiter in front of a shared registered N:1 W-bit mux.
// Optional forced revoke after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module mux_share_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 8,
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data_in,
    output logic [N-1:0]   grant,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           busy,
    output logic           timeout
);

    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

    state_e        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] pick;
    logic [IW-1:0] owner_next;
    logic          found;
    logic          release_now;
    logic          timeout_now;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(HOLD_MAX);
    logic [CW-1:0] hold_cnt;
`endif

    // First requester at or after ptr, wrapping past N-1.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned idx;
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
    end

    assign owner_next = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        timeout_now = 1'b0;
`ifdef ARB_TIMEOUT_EN
        timeout_now = req[owner] && (hold_cnt == CW'(HOLD_MAX - 1));
`endif
        release_now = !req[owner] || timeout_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            ptr       <= '0;
            owner     <= '0;
            grant     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            unique case (state)
                StIdle, StRelease: begin
                    if (|req) begin
                        state     <= StGrant;
                        owner     <= pick;
                        grant     <= N'(1) << pick;
                        out_valid <= 1'b1;
                        out_data  <= data_in[int'(pick)*W +: W];
                        busy      <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end else begin
                        state     <= StIdle;
                        grant     <= '0;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        busy      <= 1'b0;
                    end
                end
                StGrant: begin
                    if (release_now) begin
                        // Break-before-make: one dead cycle before the next owner.
                        state     <= StRelease;
                        grant     <= '0;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        busy      <= 1'b1;
                        ptr       <= owner_next;
`ifdef ARB_TIMEOUT_EN
                        timeout   <= timeout_now;
`endif
                    end else begin
                        out_data  <= data_in[int'(owner)*W +: W];
`ifdef ARB_TIMEOUT_EN
                        hold_cnt  <= hold_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    state     <= StIdle;
                    grant     <= '0;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifndef ARB_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Self-checking bench for mux_share_arbiter: directed scenarios plus randomized requesters
// compared every cycle against a behavioural round-robin model.
module tb_mux_share_arbiter;

    localparam int N        = 4;
    localparam int W        = 8;
    localparam int HOLD_MAX = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] data_in = '0;
    logic [N-1:0]   grant;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           busy;
    logic           timeout;

    mux_share_arbiter #(
        .N        (N),
        .W        (W),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: -1 means nobody owns the mux.
    int           m_owner;
    bit           m_rel;
    int           m_ptr;
    int           m_hold;
    logic [W-1:0] m_data;
    bit           m_to;

    function automatic void model_reset();
        m_owner = -1;
        m_rel   = 1'b0;
        m_ptr   = 0;
        m_hold  = 0;
        m_data  = '0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_edge();
        int p;
        m_to = 1'b0;
        if (m_owner < 0) begin
            p = -1;
            for (int k = 0; k < N; k++)
                if (p < 0 && req[(m_ptr + k) % N]) p = (m_ptr + k) % N;
            if (p >= 0) begin
                m_owner = p;
                m_hold  = 0;
                m_data  = data_in[p*W +: W];
            end
            m_rel = 1'b0;
        end else if (!req[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_rel   = 1'b1;
`ifdef ARB_TIMEOUT_EN
        end else if (m_hold == HOLD_MAX - 1) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_rel   = 1'b1;
            m_to    = 1'b1;
`endif
        end else begin
            m_data = data_in[m_owner*W +: W];
            m_hold++;
        end
    endfunction

    task automatic compare_all();
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        check("grant", grant, eg);
        check("out_valid", out_valid, m_owner >= 0);
        check("out_data", out_data, (m_owner >= 0) ? m_data : '0);
        check("busy", busy, (m_owner >= 0) || m_rel);
        check("timeout", timeout, m_to);
        check("onehot0", $onehot0(grant), 1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        data_in = '0;
        @(negedge clk);
        model_reset();
        compare_all();
        rst_n = 1'b1;
    endtask

    task automatic set_data(input int idx, input logic [W-1:0] v);
        data_in[idx*W +: W] = v;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] order [5];
        logic [N-1:0] prev;
        logic [N-1:0] after;
        int           k, held, drop_idx, cyc, run0, to_cnt;
        bit           run_open;
        int           rem [N];

        model_reset();
        do_reset();

        // Single requester, then release and idle.
        set_data(1, 8'hA5);
        req = 4'b0010;
        step();
        check("t2_grant", grant, 4'b0010);
        check("t2_data", out_data, 8'hA5);
        req = '0;
        step();
        check("t2_rel_grant", grant, 0);
        check("t2_rel_busy", busy, 1);
        step();
        check("t2_idle_busy", busy, 0);

        // Wrap-around from ptr=3.
        req = 4'b0100; step(); req = '0; step(); step();
        req = 4'b0001; step();
        check("t4_wrap0", grant, 4'b0001);
        req = '0; step(); step();
        req = 4'b0100; step(); req = '0; step(); step();
        req = 4'b1001; step();
        check("t4_wrap3", grant, 4'b1000);
        req = '0; step(); step();

        // Data tracking follows the owner only.
        set_data(1, 8'h10);
        req = 4'b0010; step();
        check("t5_d10", out_data, 8'h10);
        set_data(1, 8'h11); set_data(0, 8'h77); step();
        check("t5_d11", out_data, 8'h11);
        set_data(0, 8'h99); step();
        check("t5_d11_hold", out_data, 8'h11);
        req = '0; step(); step();

        // Asynchronous reset mid-grant.
        set_data(2, 8'h3C);
        req = 4'b0100; step();
        check("t1_pre_grant", grant, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        check("t1_grant", grant, 0);
        check("t1_valid", out_valid, 0);
        check("t1_data", out_data, 0);
        check("t1_busy", busy, 0);
        req = '0;
        @(negedge clk);
        model_reset();
        compare_all();
        rst_n = 1'b1;

        // Round robin with all requesters active.
        order    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req      = 4'b1111;
        k        = 0;
        held     = 0;
        drop_idx = -1;
        cyc      = 0;
        prev     = '0;
        while (k < 5 && cyc < 80) begin
            step();
            cyc++;
            if (drop_idx >= 0) begin
                req[drop_idx] = 1'b1;
                drop_idx      = -1;
            end
            if (grant != 0 && prev == 0) begin
                check($sformatf("t3_order%0d", k), grant, order[k]);
                k++;
                held = 0;
            end
            if (grant != 0 && m_owner >= 0) begin
                held++;
                if (held == 3) begin
                    req[m_owner] = 1'b0;
                    drop_idx     = m_owner;
                end
            end
            prev = grant;
        end
        check("t3_done", k, 5);
        req = '0; step(); step(); step();

        // Long hold by owner 0 with owner 1 waiting.
        do_reset();
        req      = 4'b0011;
        run0     = 0;
        run_open = 1'b1;
        to_cnt   = 0;
        after    = '0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (run_open && grant == 4'b0001) run0++;
            else if (run_open && run0 > 0) run_open = 1'b0;
            if (timeout) to_cnt++;
            if (!run_open && after == 0 && grant != 0) after = grant;
        end
`ifdef ARB_TIMEOUT_EN
        check("t6_run0", run0, HOLD_MAX);
        check("t6_to_cnt", to_cnt, 2);
        check("t6_next", after, 4'b0010);
`else
        check("t6_run0", run0, 40);
        check("t6_to_cnt", to_cnt, 0);
`endif
        req = '0; step(); step(); step();

        // Randomized requesters against the model.
        do_reset();
        for (int i = 0; i < N; i++) rem[i] = -1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) set_data(i, W'($urandom));
            step();
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (m_owner == i) begin
                        if (rem[i] < 0) rem[i] = $urandom_range(1, 6);
                        rem[i]--;
                        if (rem[i] == 0) begin
                            req[i] = 1'b0;
                            rem[i] = -1;
                        end
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
